// File: rtl/tpu_host_pkg.sv
// Shared types and byte-order constants for the host-side matmul driver.
// The load and result frames are both 8 bytes long.
package tpu_host_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, CAPTURE, RESP} drv_state_t;

  localparam int FRAME_BYTES = 8;
  localparam int MAT_BYTES   = 4;

  // Position of each operand byte within the load frame
  localparam logic [2:0] IDX_W00 = 3'd0, IDX_W01 = 3'd1, IDX_W10 = 3'd2, IDX_W11 = 3'd3;
  localparam logic [2:0] IDX_X00 = 3'd4, IDX_X01 = 3'd5, IDX_X10 = 3'd6, IDX_X11 = 3'd7;

  // Position of each result byte within the capture frame (MSB first)
  localparam logic [2:0] IDX_C00_HI = 3'd0, IDX_C00_LO = 3'd1, IDX_C01_HI = 3'd2, IDX_C01_LO = 3'd3;
  localparam logic [2:0] IDX_C10_HI = 3'd4, IDX_C10_LO = 3'd5, IDX_C11_HI = 3'd6, IDX_C11_LO = 3'd7;

  function automatic logic [7:0] load_byte(input logic [31:0] w, input logic [31:0] x,
                                           input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      IDX_W00: b = w[7:0];
      IDX_W01: b = w[15:8];
      IDX_W10: b = w[23:16];
      IDX_W11: b = w[31:24];
      IDX_X00: b = x[7:0];
      IDX_X01: b = x[15:8];
      IDX_X10: b = x[23:16];
      default: b = x[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/host_result_assembler.sv
// Collects the 8-byte result stream into four signed 16-bit words.
// The words reflect the byte arriving this cycle so the caller can register them on full.
module host_result_assembler
  import tpu_host_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               sample_en,
  input  logic [7:0]         byte_in,
  output logic signed [15:0] word_c00,
  output logic signed [15:0] word_c01,
  output logic signed [15:0] word_c10,
  output logic signed [15:0] word_c11,
  output logic               full
);

  logic [2:0] cnt_q, cnt_d;
  logic [7:0] bytes_q [FRAME_BYTES];
  logic [7:0] bytes_d [FRAME_BYTES];

  always_comb begin
    cnt_d   = cnt_q;
    bytes_d = bytes_q;
    full    = 1'b0;
    if (clear) begin
      cnt_d = 3'd0;
    end else if (sample_en) begin
      bytes_d[cnt_q] = byte_in;
      cnt_d          = cnt_q + 3'd1;
      full           = (cnt_q == 3'(FRAME_BYTES - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
      for (int i = 0; i < FRAME_BYTES; i++) bytes_q[i] <= 8'd0;
    end else begin
      cnt_q   <= cnt_d;
      bytes_q <= bytes_d;
    end
  end

  assign word_c00 = {bytes_d[IDX_C00_HI], bytes_d[IDX_C00_LO]};
  assign word_c01 = {bytes_d[IDX_C01_HI], bytes_d[IDX_C01_LO]};
  assign word_c10 = {bytes_d[IDX_C10_HI], bytes_d[IDX_C10_LO]};
  assign word_c11 = {bytes_d[IDX_C11_HI], bytes_d[IDX_C11_LO]};

endmodule

// File: rtl/host_matmul_driver.sv
// Host master for the 2x2 byte-serial matmul port: load 8 bytes, wait for done, capture 8 bytes.
// Define HOST_DRV_LATENCY_EN to add the last_latency accept-to-response cycle counter port.
module host_matmul_driver
  import tpu_host_pkg::*;
#(
  parameter int TIMEOUT = 32,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_weights,
  input  logic [31:0]        req_inputs,
  input  logic               req_transpose,
  output logic               load_en,
  output logic [DATA_W-1:0]  load_data,
  output logic               transpose,
  input  logic               done,
  input  logic [DATA_W-1:0]  host_outdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic signed [15:0] resp_c00,
  output logic signed [15:0] resp_c01,
  output logic signed [15:0] resp_c10,
  output logic signed [15:0] resp_c11,
  output logic               resp_timeout
`ifdef HOST_DRV_LATENCY_EN
  ,
  output logic [7:0]         last_latency
`endif
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  drv_state_t         state_q, state_d;
  logic               req_ready_q, req_ready_d;
  logic               load_en_q, load_en_d;
  logic [7:0]         load_data_q, load_data_d;
  logic               transpose_q, transpose_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_timeout_q, resp_timeout_d;
  logic signed [15:0] c00_q, c00_d, c01_q, c01_d, c10_q, c10_d, c11_q, c11_d;
  logic [31:0]        weights_q, weights_d, inputs_q, inputs_d;
  logic [3:0]         byte_idx_q, byte_idx_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic               accept, sample_en, asm_full;
  logic signed [15:0] asm_c00, asm_c01, asm_c10, asm_c11;

  assign accept    = (state_q == IDLE) && req_valid && req_ready_q;
  // The byte on the bus in the cycle done first rises is byte 0
  assign sample_en = ((state_q == WAIT) && done) || (state_q == CAPTURE);

  host_result_assembler u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .sample_en(sample_en),
    .byte_in  (host_outdata),
    .word_c00 (asm_c00),
    .word_c01 (asm_c01),
    .word_c10 (asm_c10),
    .word_c11 (asm_c11),
    .full     (asm_full)
  );

  always_comb begin
    state_d        = state_q;
    req_ready_d    = req_ready_q;
    load_en_d      = load_en_q;
    load_data_d    = load_data_q;
    transpose_d    = transpose_q;
    resp_valid_d   = resp_valid_q;
    resp_timeout_d = resp_timeout_q;
    c00_d = c00_q; c01_d = c01_q; c10_d = c10_q; c11_d = c11_q;
    weights_d      = weights_q;
    inputs_d       = inputs_q;
    byte_idx_d     = byte_idx_q;
    tmo_cnt_d      = tmo_cnt_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          weights_d   = req_weights;
          inputs_d    = req_inputs;
          transpose_d = req_transpose;
          req_ready_d = 1'b0;
          load_en_d   = 1'b1;
          load_data_d = load_byte(req_weights, req_inputs, IDX_W00);
          byte_idx_d  = 4'd1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (byte_idx_q == 4'(FRAME_BYTES)) begin
          load_en_d   = 1'b0;
          load_data_d = 8'd0;
          tmo_cnt_d   = '0;
          state_d     = WAIT;
        end else begin
          load_data_d = load_byte(weights_q, inputs_q, byte_idx_q[2:0]);
          byte_idx_d  = byte_idx_q + 4'd1;
        end
      end
      WAIT: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (done) begin
          state_d = CAPTURE;
        end else if (tmo_cnt_d == TMO_W'(TIMEOUT)) begin
          state_d        = RESP;
          resp_valid_d   = 1'b1;
          resp_timeout_d = 1'b1;
          c00_d = '0; c01_d = '0; c10_d = '0; c11_d = '0;
        end
      end
      CAPTURE: begin
        if (asm_full) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          c00_d = asm_c00; c01_d = asm_c01; c10_d = asm_c10; c11_d = asm_c11;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d        = IDLE;
          resp_valid_d   = 1'b0;
          resp_timeout_d = 1'b0;
          transpose_d    = 1'b0;
          req_ready_d    = 1'b1;
          byte_idx_d     = 4'd0;
          tmo_cnt_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      req_ready_q    <= 1'b1;
      load_en_q      <= 1'b0;
      load_data_q    <= 8'd0;
      transpose_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
      c00_q <= '0; c01_q <= '0; c10_q <= '0; c11_q <= '0;
      weights_q      <= 32'd0;
      inputs_q       <= 32'd0;
      byte_idx_q     <= 4'd0;
      tmo_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      req_ready_q    <= req_ready_d;
      load_en_q      <= load_en_d;
      load_data_q    <= load_data_d;
      transpose_q    <= transpose_d;
      resp_valid_q   <= resp_valid_d;
      resp_timeout_q <= resp_timeout_d;
      c00_q <= c00_d; c01_q <= c01_d; c10_q <= c10_d; c11_q <= c11_d;
      weights_q      <= weights_d;
      inputs_q       <= inputs_d;
      byte_idx_q     <= byte_idx_d;
      tmo_cnt_q      <= tmo_cnt_d;
    end
  end

`ifdef HOST_DRV_LATENCY_EN
  logic [7:0] lat_cnt_q, lat_cnt_d, last_lat_q, last_lat_d;

  // Accept edge counts as 0; the edge raising resp_valid adds the final cycle
  always_comb begin
    lat_cnt_d  = lat_cnt_q;
    last_lat_d = last_lat_q;
    if (accept) lat_cnt_d = 8'd0;
    else if (lat_cnt_q != 8'hFF) lat_cnt_d = lat_cnt_q + 8'd1;
    if (!resp_valid_q && resp_valid_d)
      last_lat_d = (lat_cnt_q == 8'hFF) ? 8'hFF : lat_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_cnt_q  <= 8'd0;
      last_lat_q <= 8'd0;
    end else begin
      lat_cnt_q  <= lat_cnt_d;
      last_lat_q <= last_lat_d;
    end
  end

  assign last_latency = last_lat_q;
`endif

  assign req_ready    = req_ready_q;
  assign load_en      = load_en_q;
  assign load_data    = load_data_q;
  assign transpose    = transpose_q;
  assign resp_valid   = resp_valid_q;
  assign resp_timeout = resp_timeout_q;
  assign resp_c00     = c00_q;
  assign resp_c01     = c01_q;
  assign resp_c10     = c10_q;
  assign resp_c11     = c11_q;

endmodule

// File: tb/tb_host_matmul_driver.sv
// Directed bench for host_matmul_driver: outputs sampled and inputs driven on the falling edge.
module tb_host_matmul_driver;

  logic clk = 1'b0;
  logic rst_n, req_valid, req_ready, req_transpose;
  logic [31:0] req_weights, req_inputs;
  logic load_en, transpose, done, resp_valid, resp_ready, resp_timeout;
  logic [7:0] load_data, host_outdata;
  logic signed [15:0] resp_c00, resp_c01, resp_c10, resp_c11;
`ifdef HOST_DRV_LATENCY_EN
  logic [7:0] last_latency;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  host_matmul_driver #(.TIMEOUT(32), .DATA_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_weights  (req_weights),
    .req_inputs   (req_inputs),
    .req_transpose(req_transpose),
    .load_en      (load_en),
    .load_data    (load_data),
    .transpose    (transpose),
    .done         (done),
    .host_outdata (host_outdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_c00     (resp_c00),
    .resp_c01     (resp_c01),
    .resp_c10     (resp_c10),
    .resp_c11     (resp_c11),
    .resp_timeout (resp_timeout)
`ifdef HOST_DRV_LATENCY_EN
    ,
    .last_latency (last_latency)
`endif
  );

  // Offers one job, records the 8 load bytes (0xEE where load_en is low), plays the
  // result stream done_dly cycles after the last load, then counts cycles to resp_valid.
  task automatic run_job(input logic [31:0] w, input logic [31:0] x, input logic tr,
                         input bit use_done, input int done_dly, input logic [63:0] stream,
                         input bit drop_done, output logic [63:0] seen, output bit tr_match,
                         output int rsp_wait);
    int k;
    seen = '0;
    tr_match = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_weights = w; req_inputs = x; req_transpose = tr;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen[i*8 +: 8] = (load_en === 1'b1) ? load_data : 8'hEE;
      tr_match &= (transpose === tr);
      @(negedge clk);
    end
    if (use_done) begin
      for (int i = 1; i < done_dly; i++) begin
        tr_match &= (transpose === tr);
        @(negedge clk);
      end
      for (int i = 0; i < 8; i++) begin
        done = (i == 0) || !drop_done;
        host_outdata = stream[63 - 8*i -: 8];
        tr_match &= (transpose === tr);
        @(negedge clk);
      end
      done = 1'b0; host_outdata = 8'h00;
      k = 1;
    end else begin
      k = 0;
    end
    while (resp_valid !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    rsp_wait = k;
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    tests_run++;
    if ({load_en, load_data, transpose} !== 10'd0) begin
      tests_failed++; $display("FAIL reset_load: load_en=%b load_data=%h transpose=%b want 0,00,0", load_en, load_data, transpose);
    end
    tests_run++;
    if ({resp_valid, resp_timeout} !== 2'b00 || {resp_c00, resp_c01, resp_c10, resp_c11} !== 64'd0) begin
      tests_failed++; $display("FAIL reset_resp: valid=%b timeout=%b c=%h %h %h %h want all 0",
                               resp_valid, resp_timeout, resp_c00, resp_c01, resp_c10, resp_c11);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset applied and released");
  endtask

  task automatic test_basic();
    logic [63:0] seen; bit trm; int w;
    run_job(32'h04030201, 32'h08070605, 1'b0, 1'b1, 3, 64'h0013_0016_002B_0032, 1'b0, seen, trm, w);
    $display("[TB] job basic: loads=%h c=%0d %0d %0d %0d timeout=%b", seen, resp_c00, resp_c01, resp_c10, resp_c11, resp_timeout);
    tests_run++;
    if (seen !== 64'h0807060504030201) begin tests_failed++; $display("FAIL basic_load_seq: got %h want 0807060504030201", seen); end
    tests_run++;
    if (w !== 1) begin tests_failed++; $display("FAIL basic_resp_latency: got %0d want 1", w); end
    tests_run++;
    if (resp_c00 !== 16'sd19 || resp_c01 !== 16'sd22 || resp_c10 !== 16'sd43 || resp_c11 !== 16'sd50) begin
      tests_failed++; $display("FAIL basic_results: got %0d %0d %0d %0d want 19 22 43 50", resp_c00, resp_c01, resp_c10, resp_c11);
    end
    tests_run++;
    if (resp_timeout !== 1'b0 || trm !== 1'b1) begin
      tests_failed++; $display("FAIL basic_flags: timeout=%b transpose_ok=%b want 0 1", resp_timeout, trm);
    end
`ifdef HOST_DRV_LATENCY_EN
    tests_run++;
    if (last_latency !== 8'd18) begin tests_failed++; $display("FAIL basic_latency_port: got %0d want 18", last_latency); end
`endif
    finish_resp();
    tests_run++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_c11 !== 16'sd50) begin
      tests_failed++; $display("FAIL basic_handshake: valid=%b ready=%b c11=%0d want 0 1 50", resp_valid, req_ready, resp_c11);
    end
  endtask

  task automatic test_negative();
    logic [63:0] seen; bit trm; int w;
    run_job(32'hF0E0D0C0, 32'h11223344, 1'b0, 1'b1, 1, 64'hFFF6_8000_7FFF_0000, 1'b1, seen, trm, w);
    $display("[TB] job negative: loads=%h c=%0d %0d %0d %0d", seen, resp_c00, resp_c01, resp_c10, resp_c11);
    tests_run++;
    if (seen !== 64'h11223344F0E0D0C0) begin tests_failed++; $display("FAIL neg_load_seq: got %h want 11223344f0e0d0c0", seen); end
    tests_run++;
    if (resp_c00 !== -16'sd10 || resp_c01 !== 16'sh8000 || resp_c10 !== 16'sd32767 || resp_c11 !== 16'sd0) begin
      tests_failed++; $display("FAIL neg_results: got %0d %0d %0d %0d want -10 -32768 32767 0", resp_c00, resp_c01, resp_c10, resp_c11);
    end
    finish_resp();
  endtask

  task automatic test_timeout();
    logic [63:0] seen; bit trm; int w;
    run_job(32'h01010101, 32'h02020202, 1'b0, 1'b0, 0, 64'd0, 1'b0, seen, trm, w);
    $display("[TB] job timeout: wait=%0d timeout=%b c=%0d %0d %0d %0d", w, resp_timeout, resp_c00, resp_c01, resp_c10, resp_c11);
    tests_run++;
    if (w !== 32) begin tests_failed++; $display("FAIL timeout_cycles: got %0d want 32", w); end
    tests_run++;
    if (resp_timeout !== 1'b1 || {resp_c00, resp_c01, resp_c10, resp_c11} !== 64'd0) begin
      tests_failed++; $display("FAIL timeout_resp: timeout=%b c=%h %h %h %h want 1 and zeros", resp_timeout, resp_c00, resp_c01, resp_c10, resp_c11);
    end
    finish_resp();
    tests_run++;
    if (resp_timeout !== 1'b0 || resp_valid !== 1'b0) begin
      tests_failed++; $display("FAIL timeout_clear: timeout=%b valid=%b want 0 0", resp_timeout, resp_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] seen; bit trm; int w;
    run_job(32'h04030201, 32'h08070605, 1'b0, 1'b1, 3, 64'h0013_0016_002B_0032, 1'b0, seen, trm, w);
    req_valid = 1'b1; req_weights = 32'h5A5A5AC3; req_inputs = 32'h0; req_transpose = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || load_en !== 1'b0 || resp_c00 !== 16'sd19 || resp_c11 !== 16'sd50) begin
        tests_failed++; $display("FAIL bp_hold_%0d: valid=%b ready=%b load_en=%b c00=%0d c11=%0d want 1 0 0 19 50",
                                 i, resp_valid, req_ready, load_en, resp_c00, resp_c11);
      end
      @(negedge clk);
    end
    finish_resp();
    tests_run++;
    if (req_ready !== 1'b1 || load_en !== 1'b0) begin
      tests_failed++; $display("FAIL bp_no_overlap: ready=%b load_en=%b want 1 0", req_ready, load_en);
    end
    @(negedge clk);
    req_valid = 1'b0;
    tests_run++;
    if (load_en !== 1'b1 || load_data !== 8'hC3) begin
      tests_failed++; $display("FAIL bp_next_accept: load_en=%b data=%h want 1 c3", load_en, load_data);
    end
    w = 0;
    while (resp_valid !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    tests_run++;
    if (resp_valid !== 1'b1 || resp_timeout !== 1'b1) begin
      tests_failed++; $display("FAIL bp_second_job: valid=%b timeout=%b want 1 1", resp_valid, resp_timeout);
    end
    $display("[TB] job backpressure: held 10 cycles, follow-on job accepted after handshake");
    finish_resp();
  endtask

  task automatic test_reset_mid();
    logic [63:0] seen; bit trm; int w; bit saw_resp;
    @(negedge clk);
    req_valid = 1'b1; req_weights = 32'h04030201; req_inputs = 32'h08070605; req_transpose = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (load_en !== 1'b1 || load_data !== 8'h05) begin
      tests_failed++; $display("FAIL rst_mid_byte4: load_en=%b data=%h want 1 05", load_en, load_data);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests_run++;
    if (load_en !== 1'b0 || req_ready !== 1'b1 || transpose !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid_state: load_en=%b ready=%b transpose=%b want 0 1 0", load_en, req_ready, transpose);
    end
    saw_resp = 1'b0;
    for (int i = 0; i < 60; i++) begin
      saw_resp |= (resp_valid !== 1'b0);
      @(negedge clk);
    end
    tests_run++;
    if (saw_resp !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_no_resp: resp_valid rose=%b want 0", saw_resp); end
    run_job(32'h04030201, 32'h08070605, 1'b0, 1'b1, 3, 64'h0013_0016_002B_0032, 1'b0, seen, trm, w);
    $display("[TB] job after reset: loads=%h c=%0d %0d %0d %0d", seen, resp_c00, resp_c01, resp_c10, resp_c11);
    tests_run++;
    if (seen !== 64'h0807060504030201 || resp_c00 !== 16'sd19 || resp_c10 !== 16'sd43 || resp_c11 !== 16'sd50) begin
      tests_failed++; $display("FAIL rst_mid_recover: loads=%h c00=%0d c10=%0d c11=%0d want 0807060504030201 19 43 50",
                               seen, resp_c00, resp_c10, resp_c11);
    end
    finish_resp();
  endtask

  task automatic test_transpose();
    logic [63:0] seen; bit trm; int w;
    run_job(32'h0A0B0C0D, 32'h01020304, 1'b1, 1'b1, 2, 64'h0001_0002_0003_0004, 1'b0, seen, trm, w);
    $display("[TB] job transpose: transpose=%b c=%0d %0d %0d %0d", transpose, resp_c00, resp_c01, resp_c10, resp_c11);
    tests_run++;
    if (trm !== 1'b1) begin tests_failed++; $display("FAIL tr_during_job: held=%b want 1", trm); end
    tests_run++;
    if (transpose !== 1'b1 || resp_valid !== 1'b1 || resp_c01 !== 16'sd2) begin
      tests_failed++; $display("FAIL tr_in_resp: transpose=%b valid=%b c01=%0d want 1 1 2", transpose, resp_valid, resp_c01);
    end
    finish_resp();
    tests_run++;
    if (transpose !== 1'b0) begin tests_failed++; $display("FAIL tr_after_idle: got %b want 0", transpose); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_weights = '0; req_inputs = '0; req_transpose = 1'b0;
    done = 1'b0; host_outdata = 8'h00; resp_ready = 1'b0;
    test_reset();
    test_basic();
    test_negative();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_transpose();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/host_matmul_driver.md
Name: host_matmul_driver

Overview:
- Host-side master for the TPU's 2x2 byte-serial matmul port.
- Accepts a complete job (4 weight bytes, 4 input bytes, transpose flag) on a valid/ready request channel.
- Serialises the 8 load bytes to the array controller with load_en, waits for done, then captures the 8 result bytes (MSB first).
- Reassembles them into four signed 16-bit results and returns them on a valid/ready response channel. Sits between the system bus/testbench host and the matmul control unit.

Parameters:
- TIMEOUT, 32, max cycles in WAIT for done before aborting; counter width is $clog2(TIMEOUT+1).
- DATA_W, 8, byte-bus width; only 8 is supported.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, synchronous active-low reset.
- req_valid, in, 1, job offered.
- req_ready, out, 1, driver can accept a job.
- req_weights, in, 32, {w11,w10,w01,w00}; w00 in bits [7:0].
- req_inputs, in, 32, {x11,x10,x01,x00}; x00 in bits [7:0].
- req_transpose, in, 1, transpose flag for the job.
- load_en, out, 1, byte-load strobe to the control unit.
- load_data, out, 8, byte presented with load_en.
- transpose, out, 1, job transpose flag, held for the whole job.
- done, in, 1, result stream valid from the control unit.
- host_outdata, in, 8, result byte stream.
- resp_valid, out, 1, results available.
- resp_ready, in, 1, consumer accepts results.
- resp_c00, resp_c01, resp_c10, resp_c11, out, 16 each, signed results.
- resp_timeout, out, 1, job aborted by timeout; results are 0 when set.

Behaviour:
- Reset (rst_n low at a clk edge) forces these values:
  - state IDLE.
  - req_ready=1.
  - load_en=0, load_data=0, transpose=0.
  - resp_valid=0, resp_c*=0, resp_timeout=0.
  - byte and timeout counters 0.
  - Reset mid-job abandons the job silently; no response is produced.
- States: IDLE, LOAD, WAIT, CAPTURE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch weights, inputs and transpose, go to LOAD.
- LOAD:
  - 8 consecutive cycles, load_en=1.
  - load_data in order w00,w01,w10,w11,x00,x01,x02→x10,x11 (byte index 0..7, no gaps).
  - After index 7, go to WAIT; load_en returns to 0 in the next cycle.
- WAIT:
  - Timeout counter increments each cycle.
  - done=1 → go to CAPTURE; the byte sampled in that same cycle is byte 0.
  - Counter reaching TIMEOUT with done low → go to RESP with resp_timeout=1 and results 0.
- CAPTURE:
  - Samples host_outdata every cycle, 8 bytes total, in order c00[15:8], c00[7:0], c01 hi, c01 lo, c10 hi, c10 lo, c11 hi, c11 lo.
  - Sampling is unconditional once started; done deasserting mid-capture is ignored.
  - After byte 7, go to RESP.
- RESP:
  - resp_valid=1; outputs stay stable until resp_ready.
  - On resp_valid&&resp_ready, go to IDLE and clear resp_valid and resp_timeout. resp_c* hold their last value.
- req_ready is 0 in every state except IDLE, so a new request cannot overlap a response.
- transpose is registered from the latched flag on acceptance and holds until return to IDLE.
- Latency, no stalls: accept → first load_en is 1 cycle; LOAD is 8 cycles; WAIT is N cycles; CAPTURE is 8 cycles; resp_valid rises the cycle after the last byte.
- Results are raw two's-complement concatenations with no arithmetic; signedness is carried through.

Optional Feature:
- HOST_DRV_LATENCY_EN defined:
  - Adds output port last_latency[7:0].
  - It counts cycles from request accept to resp_valid rising, saturating at 255, and updates on resp_valid rise.
  - Reset value 0.
- Undefined: no port and no counter.

Decomposition:
- Package tpu_host_pkg holds:
  - the drv_state_t enum (IDLE, LOAD, WAIT, CAPTURE, RESP);
  - FRAME_BYTES=8 and MAT_BYTES=4;
  - the byte-order index constants.
- One natural sub-module, host_result_assembler: an 8-byte shift/capture register with a byte counter, emitting the four 16-bit words and a full pulse.

Test Plan:
- Basic job:
  - Stimulus: weights 0x04030201, inputs 0x08070605; bench model asserts done 3 cycles after the last load and streams 00,13,00,16,00,2B,00,32.
  - Required: load_data sequence 01,02,03,04,05,06,07,08; resp_c00=19, c01=22, c10=43, c11=50; resp_timeout=0.
- Negative results:
  - Stimulus: stream FF,F6,80,00,7F,FF,00,00.
  - Required: c00=-10, c01=-32768, c10=32767, c11=0.
- Timeout:
  - Stimulus: done held low.
  - Required: resp_valid exactly TIMEOUT cycles after WAIT entry, with resp_timeout=1 and all results 0.
- Backpressure:
  - Stimulus: hold resp_ready=0 for 10 cycles.
  - Required: outputs stable; req_ready=0; a new req_valid is not accepted until the cycle after resp handshake.
- Reset mid-operation:
  - Stimulus: rst_n low at load byte 4.
  - Required: next cycle load_en=0, req_ready=1, resp_valid never rises; a following job completes correctly.
- Transpose:
  - Stimulus: req_transpose=1.
  - Required: transpose=1 from the first load_en cycle through RESP, 0 after return to IDLE.
